// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and counter sizing.
package seq_divider_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE
    } state_e;

    // Counter must hold the iteration count 2*width itself.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(2 * width + 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit, trial-subtract.
module div_step #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic             q_msb_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] r_o,
    output logic             q_bit_o
);

    // T is the WIDTH+1-bit trial value; the kept remainder is always < D, so fits WIDTH bits.
    logic [WIDTH:0] t;

    always_comb begin
        t       = {r_i, q_msb_i};
        q_bit_o = (t >= {1'b0, d_i});
        r_o     = q_bit_o ? WIDTH'(t - {1'b0, d_i}) : t[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [2*WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]     divisor_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   quotient_o,
    output logic [WIDTH-1:0]     remainder_o,
    output logic                 div_by_zero_o
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] Iters = CntW'(2 * WIDTH);

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]     d_q, d_d;
    logic [WIDTH-1:0]     r_q, r_d;
    logic [2*WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 dbz_q, dbz_d;

    logic [WIDTH-1:0]     step_r;
    logic                 step_q_bit;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .r_i     (r_q),
        .q_msb_i (q_q[2*WIDTH-1]),
        .d_i     (d_q),
        .r_o     (step_r),
        .q_bit_o (step_q_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    q_d = dividend_i;
                    d_d = divisor_i;
                    r_d = '0;
                    if (divisor_i != '0) begin
                        cnt_d   = Iters;
                        state_d = StRun;
                    end else begin
                        quot_d  = '1;
                        rem_d   = dividend_i[WIDTH-1:0];
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                q_d   = {q_q[2*WIDTH-2:0], step_q_bit};
                r_d   = step_r;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    quot_d  = {q_q[2*WIDTH-2:0], step_q_bit};
                    rem_d   = step_r;
                    dbz_d   = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone);
    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed plus randomized checks of seq_divider against a plain-arithmetic reference.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy, done, dbz;
    logic [7:0] quotient;
    logic [3:0] remainder;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [7:0] prev_q = '0;
    logic [3:0] prev_r = '0;
    logic       prev_z = 1'b0;

    seq_divider #(
        .WIDTH (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .busy_o        (busy),
        .done_o        (done),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge with the DUT idle; returns on the negedge of the idle cycle after DONE.
    task automatic run_div(input logic [7:0] dvd, input logic [3:0] dvs, input int inject_at,
                           input bit scramble, input string tag);
        logic [7:0] exp_q;
        logic [3:0] exp_r;
        logic       exp_z;
        int         exp_lat;
        int         n;
        bit         seen;
        if (dvs == 0) begin
            exp_q = 8'hFF; exp_r = dvd[3:0]; exp_z = 1'b1; exp_lat = 0;
        end else begin
            exp_q = dvd / dvs; exp_r = 4'(dvd % dvs); exp_z = 1'b0; exp_lat = 8;
        end
        start = 1'b1; dividend = dvd; divisor = dvs;
        @(posedge clk);
        n = 0; seen = 1'b0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            start = 1'b0;
            if (done) seen = 1'b1;
            else begin
                chk({tag, " busy"}, 32'(busy), 32'd1);
                chk({tag, " q_hold"}, 32'(quotient), 32'(prev_q));
                if (n == inject_at) begin
                    start = 1'b1; dividend = 8'd200; divisor = 4'd2;
                end
                if (scramble) begin
                    dividend = 8'($urandom); divisor = 4'($urandom);
                end
                @(posedge clk);
                n++;
            end
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, n, exp_lat);
        chk({tag, " busy_at_done"}, 32'(busy), 32'd1);
        chk({tag, " quotient"}, 32'(quotient), 32'(exp_q));
        chk({tag, " remainder"}, 32'(remainder), 32'(exp_r));
        chk({tag, " div_by_zero"}, 32'(dbz), 32'(exp_z));
        if (dvs != 0) begin
            chk({tag, " identity"}, 32'(quotient) * 32'(dvs) + 32'(remainder), 32'(dvd));
        end
        @(negedge clk);
        chk({tag, " done_width"}, 32'(done), 32'd0);
        chk({tag, " idle_after"}, 32'(busy), 32'd0);
        chk({tag, " q_stable"}, 32'(quotient), 32'(exp_q));
        prev_q = exp_q; prev_r = exp_r; prev_z = exp_z;
    endtask

    initial begin
        logic [7:0] rd;
        logic [3:0] rv;
        int         saw_done;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset quotient", 32'(quotient), 32'd0);
        chk("reset remainder", 32'(remainder), 32'd0);
        chk("reset dbz", 32'(dbz), 32'd0);

        // Back-to-back directed operations.
        run_div(8'd143, 4'd11, -1, 1'b0, "143/11");
        run_div(8'd225, 4'd15, -1, 1'b0, "225/15");
        run_div(8'd100, 4'd7,  -1, 1'b0, "100/7");
        run_div(8'd255, 4'd1,  -1, 1'b0, "255/1");
        run_div(8'd0,   4'd10, -1, 1'b0, "0/10");
        run_div(8'd24,  4'd3,  -1, 1'b0, "24/3");
        run_div(8'h5A,  4'd0,  -1, 1'b0, "5A/0");
        run_div(8'd10,  4'd3,  -1, 1'b0, "10/3");
        run_div(8'd143, 4'd11,  3, 1'b0, "ignored_start");
        run_div(8'd77,  4'd9,  -1, 1'b1, "scramble");

        // Reset part-way through RUN aborts without a done pulse.
        start = 1'b1; dividend = 8'd225; divisor = 4'd15;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort quotient", 32'(quotient), 32'd0);
        chk("abort remainder", 32'(remainder), 32'd0);
        chk("abort dbz", 32'(dbz), 32'd0);
        saw_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        chk("abort no_done", saw_done, 0);
        prev_q = '0; prev_r = '0; prev_z = 1'b0;
        run_div(8'd50, 4'd5, -1, 1'b0, "50/5");

        // Random operands, including occasional zero divisors.
        for (int i = 0; i < 24; i++) begin
            rd = 8'($urandom);
            rv = 4'($urandom_range(0, 15));
            run_div(rd, rv, -1, 1'($urandom), "random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
